// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: instruction SRAM request/response, redirect input and
// the downstream valid/ready instruction stream.
interface ifu_fetch_if;
  logic [15:0] ins_a;
  logic        ins_e;
  logic [31:0] ins;
  logic        br_e;
  logic [15:0] br_pc;
  logic        ifu_vld;
  logic [15:0] ifu_pc;
  logic [31:0] ifu_ins;
  logic        ifu_rdy;

  modport master (
    output ins_a, ins_e, ifu_vld, ifu_pc, ifu_ins,
    input  ins, br_e, br_pc, ifu_rdy
  );

  modport slave (
    input  ins_a, ins_e, ifu_vld, ifu_pc, ifu_ins,
    output ins, br_e, br_pc, ifu_rdy
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch initiator: issues sequential SRAM reads, buffers the
// one-cycle-latency responses in a PC-tagged prefetch FIFO, flushes on redirect.
module ifu_fetch #(
  parameter logic [15:0] RST_PC = 16'h0000,
  parameter int unsigned DEPTH  = 2
) (
  input logic         clk,
  input logic         rstn,
  ifu_fetch_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        state, state_nxt;
  logic          en;
  logic [15:0]   pc, req_pc, br_tgt, rst_tgt;
  logic          req_vld;
  logic [15:0]   fifo_pc  [DEPTH];
  logic [31:0]   fifo_ins [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [AW+1:0] credit;
  logic          vld, pop, push, fetch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN:  en = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign br_tgt  = bus.br_pc & 16'hFFFC;
  assign rst_tgt = RST_PC & 16'hFFFC;

  assign vld  = (cnt != '0);
  assign pop  = vld & bus.ifu_rdy;
  assign push = req_vld & ~bus.br_e;

  // A request is only issued if the FIFO will still have room when its
  // response lands, counting the response already in flight.
  assign credit = {1'b0, cnt} + (AW+2)'(req_vld) - (AW+2)'(pop);
  assign fetch  = en & ~bus.br_e & (credit < (AW+2)'(DEPTH));

  assign bus.ins_e   = fetch;
  assign bus.ins_a   = pc;
  assign bus.ifu_vld = vld;
  assign bus.ifu_pc  = vld ? fifo_pc[rd_ptr]  : '0;
  assign bus.ifu_ins = vld ? fifo_ins[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= rst_tgt;
      req_pc  <= rst_tgt;
      req_vld <= 1'b0;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else if (bus.br_e) begin
      pc      <= br_tgt;
      req_vld <= 1'b0;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      req_vld <= fetch;
      if (fetch) begin
        pc     <= pc + 16'd4;
        req_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (pop && !push) cnt <= cnt - (AW+1)'(1);
    end
  end

  // Storage needs no reset: the occupancy count masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= req_pc;
      fifo_ins[wr_ptr] <= bus.ins;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (cnt <= (AW+1)'(DEPTH));
      assert (!(push && !pop && cnt == (AW+1)'(DEPTH)));
    end
  end
endmodule
